mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Main sequencer for the multicycle RV32I datapath. Decodes op/funct3/funct7b5 and ALU Flags.
//  Drives every datapath select/enable one state per cycle: fetch, decode, execute, memory, writeback.
//  Also keeps a retired-instruction counter.
// PARAMETERS
//  CNT_W     32   width of instret counter (wraps modulo 2^CNT_W)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   synchronous reset, ACTIVE-HIGH (name kept for direct top-level wiring)
//  op           in   7   Instr[6:0]
//  funct3       in   3   Instr[14:12]
//  funct7b5     in   1   Instr[30]
//  Flags        in   4   {N,Z,C,V} from ALU; C=1 means no borrow on subtract
//  ImmSrc       out  3   000 I, 001 S, 010 B, 011 J, 100 U
//  ALUSrcA      out  2   00 PC, 01 OldPC, 10 A
//  ALUSrcB      out  2   00 WriteData, 01 immext, 10 const 4
//  ResultSrc    out  2   00 ALUOut, 01 Data, 10 ALUResult
//  AdrSrc       out  1   0 PC, 1 Result
//  IRWrite/PCWrite/RegWrite/MemWrite  out 1 each  strobes
//  alucontrol   out  4   0 add,1 sub,2 and,3 or,4 xor,5 slt,6 sltu,7 sll,8 srl,9 sra
//  LoadType     out  1   1 in MEMREAD/MEMWB for sub-word loads (funct3!=010)
//  StoreType    out  1   1 in MEMWRITE for sb/sh (funct3!=010)
//  PCTargetSrc  out  1   1 only in JALR state
//  instret      out  CNT_W  count of completed instructions
//  illegal      out  1   sticky illegal-opcode flag (0 when CTRL_ILLEGAL_TRAP_EN undefined)
// BEHAVIOUR
//  - Reset: state=FETCH, instret=0, illegal=0. All strobes are Moore outputs of state and are 0
//    while rst_n=1. Reset mid-instruction abandons it with no writes.
//  - Defaults each state: strobes 0, selects 00, alucontrol add, ImmSrc from op.
//  - FETCH: AdrSrc=0, IRWrite=1, SrcA=PC, SrcB=4, add, ResultSrc=10, PCWrite=1 -> DECODE.
//  - DECODE: SrcA=OldPC, SrcB=imm (B/J), add -> ALUOut = branch/jal target. Next state by op:
//    03 MEMADR | 23 MEMADR | 33 EXECR | 13 EXECI | 63 BRANCH | 6F JAL | 67 JALR | 37 LUI | 17 AUIPC.
//  - MEMADR: SrcA=A, SrcB=imm (I load, S store), add -> MEMREAD (load) or MEMWRITE (store).
//  - MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB. MEMWB: ResultSrc=01, RegWrite -> FETCH.
//  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite -> FETCH.
//  - EXECR: SrcA=A, SrcB=WriteData. Sub iff funct3=000 & funct7b5. Sra iff 101 & funct7b5 -> ALUWB.
//  - EXECI: SrcA=A, SrcB=imm I; never sub; srai iff 101 & funct7b5 -> ALUWB.
//  - ALUWB: ResultSrc=00, RegWrite -> FETCH.
//  - BRANCH: SrcA=A, SrcB=WriteData, sub, ResultSrc=00. PCWrite=taken:
//    beq Z, bne !Z, blt N^V, bge !(N^V), bltu !C, bgeu C. Reserved funct3 010/011 never taken -> FETCH.
//  - JAL: ResultSrc=00, PCWrite. ALU computes OldPC+4 into ALUOut -> ALUWB.
//  - JALR: SrcA=A, SrcB=imm I, add, PCTargetSrc=1 -> JALR_PC.
//    JALR_PC: ResultSrc=00, PCWrite, ALU OldPC+4 -> ALUWB. Correct when rd==rs1, since A is latched.
//  - LUI: SrcA=A (datapath forces rs1=x0), SrcB=imm U, add -> ALUWB.
//    AUIPC: SrcA=OldPC, SrcB=imm U -> ALUWB.
//  - Latencies (cycles): load 5, R/I/store/lui/auipc 4, jal 4, jalr 5, branch 3.
//  - instret increments by 1 on every transition into FETCH from a non-FETCH state.
//    Reset has priority over the increment.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined: unknown op in DECODE -> HALT.
//    HALT: all strobes 0, illegal=1, stays until reset, instret frozen.
//  CTRL_ILLEGAL_TRAP_EN undefined: unknown op -> FETCH as a NOP (counts in instret); illegal tied 0.
// TESTING
//  1 reset held 3 cycles then released -> FETCH strobes (IRWrite=PCWrite=1) on first cycle, instret=0.
//  2 add x3,x1,x2 (x1=5,x2=7) -> RegWrite in cycle 4, x3=12, instret=1.
//    sub -> alucontrol=1, x3=-2.
//  3 lw then sw, addr 0x100 -> MemWrite only in MEMWRITE, AdrSrc=1.
//    lw RegWrite at cycle 5, ResultSrc=01.
//  4 blt with x1=-1,x2=1 -> PCWrite in cycle 3, PC=target.
//    bltu same operands -> not taken, PC=OldPC+4.
//  5 jalr x1,0(x1) with x1=0x40 at PC 0x10 -> PC=0x40, x1=0x14.
//  6 op=0x7F: with CTRL_ILLEGAL_TRAP_EN -> illegal=1, no strobes until reset.
//    Without it -> back to FETCH, instret+1.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle RV32I sequencer (master) and its datapath (slave).
interface mc_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic [3:0]       Flags;
  logic [2:0]       ImmSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ResultSrc;
  logic             AdrSrc;
  logic             IRWrite;
  logic             PCWrite;
  logic             RegWrite;
  logic             MemWrite;
  logic [3:0]       alucontrol;
  logic             LoadType;
  logic             StoreType;
  logic             PCTargetSrc;
  logic [CNT_W-1:0] instret;
  logic             illegal;

  modport master (
    input  op, funct3, funct7b5, Flags,
    output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite, RegWrite,
           MemWrite, alucontrol, LoadType, StoreType, PCTargetSrc, instret, illegal
  );

  modport slave (
    output op, funct3, funct7b5, Flags,
    input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite, RegWrite,
           MemWrite, alucontrol, LoadType, StoreType, PCTargetSrc, instret, illegal
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I main sequencer: one state per cycle (branch 3, load/jalr 5, others 4) plus instret.
// CTRL_ILLEGAL_TRAP_EN: unknown opcodes park the FSM in HALT with a sticky illegal flag; else they retire as NOPs.
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_control_fsm_if.master  ctrl_if
);

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_PC, S_LUI, S_AUIPC, S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instret;
  logic [2:0]       w_imm;
  logic [1:0]       w_srca, w_srcb, w_res;
  logic             w_adr, w_irw, w_pcw, w_rw, w_mw, w_lt, w_st, w_pct;
  logic [3:0]       w_alu;
  logic             w_taken;

  // allow_sub separates R-type (funct7b5 selects sub) from I-type (addi never subtracts).
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7b5,
                                         input logic allow_sub);
    case (f3)
      3'b000:  alu_dec = (allow_sub && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  endfunction

  // Flags = {N,Z,C,V}; C set means no borrow, so unsigned less-than is !C.
  always_comb begin
    case (ctrl_if.funct3)
      3'b000:  w_taken = ctrl_if.Flags[2];
      3'b001:  w_taken = !ctrl_if.Flags[2];
      3'b100:  w_taken = ctrl_if.Flags[3] ^ ctrl_if.Flags[0];
      3'b101:  w_taken = !(ctrl_if.Flags[3] ^ ctrl_if.Flags[0]);
      3'b110:  w_taken = !ctrl_if.Flags[1];
      3'b111:  w_taken = ctrl_if.Flags[1];
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != S_FETCH && w_next == S_FETCH) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (ctrl_if.op)
      OP_LOAD, OP_I, OP_JALR: w_imm = 3'b000;
      OP_STORE:               w_imm = 3'b001;
      OP_BR:                  w_imm = 3'b010;
      OP_JAL:                 w_imm = 3'b011;
      OP_LUI, OP_AUIPC:       w_imm = 3'b100;
      default:                w_imm = 3'b000;
    endcase
    w_srca = 2'b00;
    w_srcb = 2'b00;
    w_res  = 2'b00;
    w_adr  = 1'b0;
    w_irw  = 1'b0;
    w_pcw  = 1'b0;
    w_rw   = 1'b0;
    w_mw   = 1'b0;
    w_alu  = ALU_ADD;
    w_lt   = 1'b0;
    w_st   = 1'b0;
    w_pct  = 1'b0;
    // Outputs stay at defaults while reset is asserted so an abandoned instruction writes nothing.
    if (!rst_n) begin
      case (r_state)
        S_FETCH: begin
          w_irw = 1'b1; w_pcw = 1'b1; w_srcb = 2'b10; w_res = 2'b10;
          w_next = S_DECODE;
        end
        S_DECODE: begin
          w_srca = 2'b01; w_srcb = 2'b01;
          case (ctrl_if.op)
            OP_LOAD, OP_STORE: w_next = S_MEMADR;
            OP_R:              w_next = S_EXECR;
            OP_I:              w_next = S_EXECI;
            OP_BR:             w_next = S_BRANCH;
            OP_JAL:            w_next = S_JAL;
            OP_JALR:           w_next = S_JALR;
            OP_LUI:            w_next = S_LUI;
            OP_AUIPC:          w_next = S_AUIPC;
`ifdef CTRL_ILLEGAL_TRAP_EN
            default:           w_next = S_HALT;
`else
            default:           w_next = S_FETCH;
`endif
          endcase
        end
        S_MEMADR: begin
          w_srca = 2'b10; w_srcb = 2'b01;
          w_next = (ctrl_if.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: begin
          w_adr = 1'b1; w_lt = (ctrl_if.funct3 != 3'b010);
          w_next = S_MEMWB;
        end
        S_MEMWB: begin
          w_res = 2'b01; w_rw = 1'b1; w_lt = (ctrl_if.funct3 != 3'b010);
          w_next = S_FETCH;
        end
        S_MEMWRITE: begin
          w_adr = 1'b1; w_mw = 1'b1; w_st = (ctrl_if.funct3 != 3'b010);
          w_next = S_FETCH;
        end
        S_EXECR: begin
          w_srca = 2'b10;
          w_alu  = alu_dec(ctrl_if.funct3, ctrl_if.funct7b5, 1'b1);
          w_next = S_ALUWB;
        end
        S_EXECI: begin
          w_srca = 2'b10; w_srcb = 2'b01;
          w_alu  = alu_dec(ctrl_if.funct3, ctrl_if.funct7b5, 1'b0);
          w_next = S_ALUWB;
        end
        S_ALUWB: begin
          w_rw = 1'b1;
          w_next = S_FETCH;
        end
        S_BRANCH: begin
          w_srca = 2'b10; w_alu = ALU_SUB; w_pcw = w_taken;
          w_next = S_FETCH;
        end
        // PC takes the target held in ALUOut while the ALU forms the link value OldPC+4.
        S_JAL: begin
          w_srca = 2'b01; w_srcb = 2'b10; w_pcw = 1'b1;
          w_next = S_ALUWB;
        end
        S_JALR: begin
          w_srca = 2'b10; w_srcb = 2'b01; w_pct = 1'b1;
          w_next = S_JALR_PC;
        end
        S_JALR_PC: begin
          w_srca = 2'b01; w_srcb = 2'b10; w_pcw = 1'b1;
          w_next = S_ALUWB;
        end
        S_LUI: begin
          w_srca = 2'b10; w_srcb = 2'b01;
          w_next = S_ALUWB;
        end
        S_AUIPC: begin
          w_srca = 2'b01; w_srcb = 2'b01;
          w_next = S_ALUWB;
        end
        S_HALT:  w_next = S_HALT;
        default: w_next = S_FETCH;
      endcase
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_illegal <= 1'b0;
    end else if (w_next == S_HALT) begin
      r_illegal <= 1'b1;
    end
  end
  assign ctrl_if.illegal = r_illegal;
`else
  assign ctrl_if.illegal = 1'b0;
`endif

  assign ctrl_if.ImmSrc      = w_imm;
  assign ctrl_if.ALUSrcA     = w_srca;
  assign ctrl_if.ALUSrcB     = w_srcb;
  assign ctrl_if.ResultSrc   = w_res;
  assign ctrl_if.AdrSrc      = w_adr;
  assign ctrl_if.IRWrite     = w_irw;
  assign ctrl_if.PCWrite     = w_pcw;
  assign ctrl_if.RegWrite    = w_rw;
  assign ctrl_if.MemWrite    = w_mw;
  assign ctrl_if.alucontrol  = w_alu;
  assign ctrl_if.LoadType    = w_lt;
  assign ctrl_if.StoreType   = w_st;
  assign ctrl_if.PCTargetSrc = w_pct;
  assign ctrl_if.instret     = r_instret;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction expected control sequences queued by the driver, checked each cycle.
module tb_mc_control_fsm;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mc_control_fsm_if #(.CNT_W(32)) bus();
  mc_control_fsm #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .ctrl_if(bus));

  typedef struct packed {
    logic [2:0] imm;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] res;
    logic       adr, ir, pcw, rw, mw;
    logic [3:0] alu;
    logic       lt, st, pct;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       c;
    logic [31:0] instret;
    logic        illegal;
  } exp_t;

  exp_t        exp_q[$];
  ctrl_t       seq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] exp_instret;
  logic        exp_illegal;
  logic [6:0]  legal_ops [0:8] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  logic [6:0]  bad_ops   [0:3] = '{7'h7F, 7'h0B, 7'h73, 7'h00};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ctrl_t mk(input logic [2:0] imm, input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] res, input logic adr, input logic ir,
                               input logic pcw, input logic rw, input logic mw,
                               input logic [3:0] alu, input logic lt, input logic st,
                               input logic pct);
    mk = {imm, a, b, res, adr, ir, pcw, rw, mw, alu, lt, st, pct};
  endfunction

  function automatic exp_t word(input ctrl_t c, input logic [31:0] n, input logic il);
    word.c = c; word.instret = n; word.illegal = il;
  endfunction

  // Immediate format implied by the RV32I instruction class.
  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'h23:        imm_of = 3'b001;
      7'h63:        imm_of = 3'b010;
      7'h6F:        imm_of = 3'b011;
      7'h37, 7'h17: imm_of = 3'b100;
      default:      imm_of = 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] alu_exp(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'd0: alu_exp = (is_r && f7) ? 4'd1 : 4'd0;
      3'd1: alu_exp = 4'd7;
      3'd2: alu_exp = 4'd5;
      3'd3: alu_exp = 4'd6;
      3'd4: alu_exp = 4'd4;
      3'd5: alu_exp = f7 ? 4'd9 : 4'd8;
      3'd6: alu_exp = 4'd3;
      default: alu_exp = 4'd2;
    endcase
  endfunction

  function automatic logic taken_exp(input logic [2:0] f3, input logic [3:0] fl);
    logic n, z, c, v;
    {n, z, c, v} = fl;
    case (f3)
      3'd0: taken_exp = z;
      3'd1: taken_exp = !z;
      3'd4: taken_exp = (n != v);
      3'd5: taken_exp = (n == v);
      3'd6: taken_exp = !c;
      3'd7: taken_exp = c;
      default: taken_exp = 1'b0;
    endcase
  endfunction

  function automatic ctrl_t idle_c();
    idle_c = mk(imm_of(bus.op), 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0);
  endfunction

  // Expected control word per cycle of one instruction, derived from its class.
  task automatic build_seq(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [3:0] fl);
    logic [2:0] im;
    logic       sub;
    ctrl_t      wb;
    im  = imm_of(op);
    sub = (f3 != 3'b010);
    wb  = mk(im, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 4'd0, 0, 0, 0);
    seq.delete();
    seq.push_back(mk(im, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 4'd0, 0, 0, 0));
    seq.push_back(mk(im, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0));
    case (op)
      7'h03: begin
        seq.push_back(mk(im, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0));
        seq.push_back(mk(im, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 4'd0, sub, 0, 0));
        seq.push_back(mk(im, 2'b00, 2'b00, 2'b01, 0, 0, 0, 1, 0, 4'd0, sub, 0, 0));
      end
      7'h23: begin
        seq.push_back(mk(im, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0));
        seq.push_back(mk(im, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 4'd0, 0, sub, 0));
      end
      7'h33: begin
        seq.push_back(mk(im, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, alu_exp(f3, f7, 1), 0, 0, 0));
        seq.push_back(wb);
      end
      7'h13: begin
        seq.push_back(mk(im, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, alu_exp(f3, f7, 0), 0, 0, 0));
        seq.push_back(wb);
      end
      7'h63: seq.push_back(mk(im, 2'b10, 2'b00, 2'b00, 0, 0, taken_exp(f3, fl), 0, 0, 4'd1, 0, 0, 0));
      7'h6F: begin
        seq.push_back(mk(im, 2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0));
        seq.push_back(wb);
      end
      7'h67: begin
        seq.push_back(mk(im, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 4'd0, 0, 0, 1));
        seq.push_back(mk(im, 2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0));
        seq.push_back(wb);
      end
      7'h37: begin
        seq.push_back(mk(im, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0));
        seq.push_back(wb);
      end
      7'h17: begin
        seq.push_back(mk(im, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0));
        seq.push_back(wb);
      end
      default: ;
    endcase
  endtask

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b1;
    step(word(idle_c(), exp_instret, exp_illegal));
    exp_instret = 0;
    exp_illegal = 1'b0;
    for (int i = 1; i < n; i++) step(word(idle_c(), 0, 1'b0));
    rst_n = 1'b0;
  endtask

  // cut > 0 abandons the instruction with a reset after that many cycles.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [3:0] fl, input int cut);
    int n;
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.Flags = fl;
    build_seq(op, f3, f7, fl);
`ifdef CTRL_ILLEGAL_TRAP_EN
    if (seq.size() == 2) begin
      step(word(seq[0], exp_instret, 1'b0));
      step(word(seq[1], exp_instret, 1'b0));
      exp_illegal = 1'b1;
      for (int i = 0; i < 3; i++) step(word(idle_c(), exp_instret, 1'b1));
      do_reset(1);
      return;
    end
`endif
    n = (cut > 0 && cut < seq.size()) ? cut : seq.size();
    for (int i = 0; i < n; i++) step(word(seq[i], exp_instret, exp_illegal));
    if (n < seq.size()) do_reset(1 + int'($urandom_range(0, 1)));
    else exp_instret = exp_instret + 1;
  endtask

  initial begin : monitor
    exp_t  e;
    ctrl_t act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc, bus.IRWrite,
               bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.alucontrol, bus.LoadType,
               bus.StoreType, bus.PCTargetSrc};
        n_checks++;
        if (act !== e.c) begin
          n_fail++;
          $display("FAIL ctrl cyc=%0d op=%h got=%h want=%h", cyc, bus.op, act, e.c);
        end
        n_checks++;
        if (bus.instret !== e.instret || bus.illegal !== e.illegal) begin
          n_fail++;
          $display("FAIL instret/illegal cyc=%0d got=%0d/%b want=%0d/%b",
                   cyc, bus.instret, bus.illegal, e.instret, e.illegal);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    n_fail++;
    $display("FAIL watchdog: run did not complete, queue depth %0d", exp_q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [6:0] op;
    int         cut;
    rst_n = 1'b1;
    bus.op = 7'h13; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.Flags = 4'd0;
    exp_instret = 0;
    exp_illegal = 1'b0;
    @(posedge clk);
    #1;
    step(word(idle_c(), 0, 1'b0));
    step(word(idle_c(), 0, 1'b0));
    rst_n = 1'b0;

    run_instr(7'h33, 3'b000, 1'b0, 4'b0000, 0);   // add
    run_instr(7'h33, 3'b000, 1'b1, 4'b1000, 0);   // sub
    run_instr(7'h03, 3'b010, 1'b0, 4'b0000, 0);   // lw
    run_instr(7'h23, 3'b010, 1'b0, 4'b0000, 0);   // sw
    run_instr(7'h63, 3'b100, 1'b0, 4'b1010, 0);   // blt -1 < 1: taken
    run_instr(7'h63, 3'b110, 1'b0, 4'b1010, 0);   // bltu same operands: not taken
    run_instr(7'h67, 3'b000, 1'b0, 4'b0000, 0);   // jalr
    run_instr(7'h03, 3'b100, 1'b0, 4'b0000, 0);   // lbu
    run_instr(7'h23, 3'b000, 1'b0, 4'b0000, 0);   // sb
    run_instr(7'h63, 3'b010, 1'b0, 4'b0100, 0);   // reserved funct3
    run_instr(7'h13, 3'b101, 1'b1, 4'b0000, 0);   // srai
    run_instr(7'h03, 3'b010, 1'b0, 4'b0000, 4);   // load abandoned in MEMREAD
    run_instr(7'h7F, 3'b000, 1'b0, 4'b0000, 0);   // unknown opcode

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 3)];
      else                           op = legal_ops[$urandom_range(0, 8)];
      cut = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), cut);
    end

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected words left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
